// File: rtl/spi_cmd_bridge.sv
// SPI command decoder: byte-wide register write/read, status readout and counted FIFO
// bursts with underrun fill and deselect abort.
module spi_cmd_bridge #(
  parameter int unsigned NUM_REGS      = 4,
  parameter int unsigned LVL_W         = 6,
  parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ssel,
  input  logic                  spi_rxdy,
  input  logic                  spi_txcomp,
  input  logic [7:0]            spi_rx_dat,
  output logic [7:0]            spi_tx_dat,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic                  fifo_rd,
  input  logic [7:0]            fifo_dat,
  input  logic                  fifo_empty,
  input  logic                  fifo_full,
  input  logic [LVL_W-1:0]      fifo_level,
  output logic                  busy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWrData = 3'd1;
  localparam logic [2:0] StBLen   = 3'd2;
  localparam logic [2:0] StBFetch = 3'd3;
  localparam logic [2:0] StBLoad  = 3'd4;
  localparam logic [2:0] StBWait  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [5:0]            addr_q, addr_d;
  logic [8:0]            rem_q, rem_d;
  logic [7:0]            tx_q, tx_d;
  logic [8*NUM_REGS-1:0] regs_q, regs_d;
  logic                  under_q, under_d;
  logic                  popped_q, popped_d;
  logic                  rxdy_q, txcomp_q, ssel_q;

  logic       rx_ev, tx_ev, desel;
  logic [7:0] rd_byte, stat_byte;
  logic [4:0] lvl_sat;
  logic [31:0] lvl_ext;

  assign rx_ev = rxdy_q & ~spi_rxdy;
  assign tx_ev = txcomp_q & ~spi_txcomp;
  assign desel = ~ssel_q & ssel;

  // A deselect in the fetch cycle must not consume a FIFO byte.
  assign fifo_rd    = (state_q == StBFetch) && !fifo_empty && !desel;
  assign busy       = (state_q != StIdle);
  assign spi_tx_dat = tx_q;
  assign regs_o     = regs_q;

  assign lvl_ext   = 32'(fifo_level);
  assign lvl_sat   = (lvl_ext > 32'd31) ? 5'd31 : lvl_ext[4:0];
  assign stat_byte = {under_q, fifo_full, fifo_empty, lvl_sat};

  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (spi_rx_dat[5:0] == 6'(k)) rd_byte = regs_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    tx_d     = tx_q;
    regs_d   = regs_q;
    under_d  = under_q;
    popped_d = fifo_rd;
    if (desel) begin
      state_d = StIdle;
      rem_d   = 9'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (rx_ev) begin
            case (spi_rx_dat[7:6])
              2'b00: begin
                addr_d  = spi_rx_dat[5:0];
                state_d = StWrData;
              end
              2'b01:   tx_d = rd_byte;
              2'b10:   state_d = StBLen;
              default: begin
                tx_d    = stat_byte;
                under_d = 1'b0;
              end
            endcase
          end
        end
        StWrData: begin
          if (rx_ev) begin
            for (int k = 0; k < NUM_REGS; k++) begin
              if (addr_q == 6'(k)) regs_d[8*k +: 8] = spi_rx_dat;
            end
            state_d = StIdle;
          end
        end
        StBLen: begin
          if (rx_ev) begin
            rem_d   = (spi_rx_dat == 8'd0) ? 9'd256 : {1'b0, spi_rx_dat};
            state_d = StBFetch;
          end
        end
        StBFetch: begin
          rem_d   = rem_q - 9'd1;
          state_d = StBLoad;
        end
        StBLoad: begin
          if (popped_q) begin
            tx_d = fifo_dat;
          end else begin
            tx_d    = UNDERRUN_BYTE;
            under_d = 1'b1;
          end
          state_d = (rem_q == 9'd0) ? StIdle : StBWait;
        end
        StBWait: begin
          // rx_ev here is a master dummy byte and is dropped.
          if (tx_ev) state_d = StBFetch;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      addr_q   <= 6'd0;
      rem_q    <= 9'd0;
      tx_q     <= 8'h00;
      regs_q   <= '0;
      under_q  <= 1'b0;
      popped_q <= 1'b0;
      rxdy_q   <= 1'b0;
      txcomp_q <= 1'b0;
      ssel_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      tx_q     <= tx_d;
      regs_q   <= regs_d;
      under_q  <= under_d;
      popped_q <= popped_d;
      rxdy_q   <= spi_rxdy;
      txcomp_q <= spi_txcomp;
      ssel_q   <= ssel;
    end
  end

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Bench for spi_cmd_bridge: byte-level SPI handshakes, a modelled capture FIFO and a
// scoreboard of expected tx bytes.
module tb_spi_cmd_bridge;
  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ssel = 1'b0;
  logic          spi_rxdy = 1'b0;
  logic          spi_txcomp = 1'b0;
  logic [7:0]    spi_rx_dat = 8'h00;
  logic [7:0]    spi_tx_dat;
  logic [8*NR-1:0] regs_o;
  logic          fifo_rd;
  logic [7:0]    fifo_dat = 8'h00;
  logic          fifo_empty, fifo_full;
  logic [5:0]    fifo_level;
  logic          busy;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic [31:0] regs_exp = 32'h0;

  // FIFO model: wp written by stimulus, rp by the pop process.
  logic [7:0] mem[512];
  int wp = 0;
  int rp = 0;
  int pops = 0;
  int bad_pops = 0;
  int lvl;

  assign lvl        = wp - rp;
  assign fifo_empty = (lvl == 0);
  assign fifo_full  = (lvl >= 64);
  assign fifo_level = (lvl > 63) ? 6'd63 : 6'(lvl);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd) begin
      pops <= pops + 1;
      if (wp == rp) begin
        bad_pops <= bad_pops + 1;
      end else begin
        fifo_dat <= mem[rp[8:0]];
        rp       <= rp + 1;
      end
    end
  end

  spi_cmd_bridge #(
    .NUM_REGS     (NR),
    .LVL_W        (6),
    .UNDERRUN_BYTE(8'hFF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ssel      (ssel),
    .spi_rxdy  (spi_rxdy),
    .spi_txcomp(spi_txcomp),
    .spi_rx_dat(spi_rx_dat),
    .spi_tx_dat(spi_tx_dat),
    .regs_o    (regs_o),
    .fifo_rd   (fifo_rd),
    .fifo_dat  (fifo_dat),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full),
    .fifo_level(fifo_level),
    .busy      (busy)
  );

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that consumed the rx_ev cycle.
  task automatic rx_byte(input logic [7:0] b);
    @(posedge clk);
    #1 spi_rx_dat = b;
    spi_rxdy = 1'b1;
    @(posedge clk);
    #1 spi_rxdy = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic tx_pulse;
    @(posedge clk);
    #1 spi_txcomp = 1'b1;
    @(posedge clk);
    #1 spi_txcomp = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] b);
    mem[wp[8:0]] = b;
    wp = wp + 1;
  endtask

  task automatic test_reset;
    #12;
    total++;
    if (spi_tx_dat !== 8'h00) begin
      $display("FAIL reset_tx got=%h want=00", spi_tx_dat); bad++;
    end
    total++;
    if (regs_o !== 32'h0) begin
      $display("FAIL reset_regs got=%h want=0", regs_o); bad++;
    end
    total++;
    if (fifo_rd !== 1'b0) begin
      $display("FAIL reset_fifo_rd got=%b want=0", fifo_rd); bad++;
    end
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_busy got=%b want=0", busy); bad++;
    end
    rst = 1'b1;
    settle(2);
  endtask

  task automatic test_wr_rd;
    rx_byte(8'h02);
    total++;
    if (busy !== 1'b1) begin
      $display("FAIL wr_busy got=%b want=1", busy); bad++;
    end
    rx_byte(8'hA5);
    regs_exp[23:16] = 8'hA5;
    total++;
    if (regs_o !== regs_exp) begin
      $display("FAIL wr_regs got=%h want=%h", regs_o, regs_exp); bad++;
    end
    exp_q.push_back(8'hA5);
    rx_byte(8'h42);
    exp_b = exp_q.pop_front();
    total++;
    if (spi_tx_dat !== exp_b) begin
      $display("FAIL rd_data got=%h want=%h", spi_tx_dat, exp_b); bad++;
    end
  endtask

  task automatic test_bad_addr;
    rx_byte(8'h05);
    rx_byte(8'h3C);
    total++;
    if (regs_o !== regs_exp) begin
      $display("FAIL badaddr_regs got=%h want=%h", regs_o, regs_exp); bad++;
    end
    exp_q.push_back(8'h00);
    rx_byte(8'h45);
    exp_b = exp_q.pop_front();
    total++;
    if (spi_tx_dat !== exp_b) begin
      $display("FAIL badaddr_rd got=%h want=%h", spi_tx_dat, exp_b); bad++;
    end
  endtask

  task automatic test_burst3;
    int p0;
    logic [7:0] prev;
    p0 = pops;
    preload(8'h11); preload(8'h22); preload(8'h33);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    rx_byte(8'h80);
    rx_byte(8'h03);
    settle(2);
    exp_b = exp_q.pop_front();
    total++;
    if (spi_tx_dat !== exp_b) begin
      $display("FAIL burst3_b0 got=%h want=%h", spi_tx_dat, exp_b); bad++;
    end
    prev = exp_b;
    rx_byte(8'h00);  // dummy byte, must not start a WR
    tx_pulse();
    settle(1);
    total++;
    if (spi_tx_dat !== prev) begin
      $display("FAIL burst3_latency got=%h want=%h", spi_tx_dat, prev); bad++;
    end
    settle(1);
    exp_b = exp_q.pop_front();
    total++;
    if (spi_tx_dat !== exp_b) begin
      $display("FAIL burst3_b1 got=%h want=%h", spi_tx_dat, exp_b); bad++;
    end
    tx_pulse();
    settle(2);
    exp_b = exp_q.pop_front();
    total++;
    if (spi_tx_dat !== exp_b) begin
      $display("FAIL burst3_b2 got=%h want=%h", spi_tx_dat, exp_b); bad++;
    end
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL burst3_idle busy=%b want=0", busy); bad++;
    end
    tx_pulse();
    settle(2);
    total++;
    if (pops - p0 !== 3) begin
      $display("FAIL burst3_pops got=%0d want=3", pops - p0); bad++;
    end
    total++;
    if (regs_o !== regs_exp) begin
      $display("FAIL burst3_regs got=%h want=%h", regs_o, regs_exp); bad++;
    end
  endtask

  task automatic test_underrun;
    int p0;
    p0 = pops;
    preload(8'h5A);
    exp_q.push_back(8'h5A); exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    rx_byte(8'h80);
    rx_byte(8'h03);
    settle(2);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        tx_pulse();
        settle(2);
      end
      exp_b = exp_q.pop_front();
      total++;
      if (spi_tx_dat !== exp_b) begin
        $display("FAIL underrun_b%0d got=%h want=%h", i, spi_tx_dat, exp_b); bad++;
      end
    end
    total++;
    if (pops - p0 !== 1) begin
      $display("FAIL underrun_pops got=%0d want=1", pops - p0); bad++;
    end
    exp_q.push_back(8'hA0); exp_q.push_back(8'h20);
    for (int i = 0; i < 2; i++) begin
      rx_byte(8'hC0);
      exp_b = exp_q.pop_front();
      total++;
      if (spi_tx_dat !== exp_b) begin
        $display("FAIL underrun_stat%0d got=%h want=%h", i, spi_tx_dat, exp_b); bad++;
      end
    end
  endtask

  task automatic test_len0;
    int p0;
    logic [7:0] v;
    p0 = pops;
    for (int i = 0; i < 64; i++) begin
      v = 8'((i * 7 + 3) & 255);
      preload(v);
      exp_q.push_back(v);
    end
    for (int i = 0; i < 192; i++) exp_q.push_back(8'hFF);
    rx_byte(8'h80);
    rx_byte(8'h00);
    settle(2);
    for (int i = 0; i < 256; i++) begin
      if (i > 0) begin
        tx_pulse();
        settle(2);
      end
      exp_b = exp_q.pop_front();
      total++;
      if (spi_tx_dat !== exp_b) begin
        $display("FAIL len0_b%0d got=%h want=%h", i, spi_tx_dat, exp_b); bad++;
      end
    end
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL len0_idle busy=%b want=0", busy); bad++;
    end
    total++;
    if (pops - p0 !== 64) begin
      $display("FAIL len0_pops got=%0d want=64", pops - p0); bad++;
    end
    exp_q.push_back(8'hA0);
    rx_byte(8'hC0);
    exp_b = exp_q.pop_front();
    total++;
    if (spi_tx_dat !== exp_b) begin
      $display("FAIL len0_stat got=%h want=%h", spi_tx_dat, exp_b); bad++;
    end
  endtask

  task automatic test_stat_sat;
    for (int i = 0; i < 40; i++) preload(8'(8'h80 + i));
    exp_q.push_back(8'h1F);
    rx_byte(8'hC0);
    exp_b = exp_q.pop_front();
    total++;
    if (spi_tx_dat !== exp_b) begin
      $display("FAIL stat_sat got=%h want=%h", spi_tx_dat, exp_b); bad++;
    end
  endtask

  task automatic test_deselect;
    int p0;
    p0 = pops;
    exp_q.push_back(8'h80); exp_q.push_back(8'h81);
    rx_byte(8'h80);
    rx_byte(8'h05);
    settle(2);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin
        tx_pulse();
        settle(2);
      end
      exp_b = exp_q.pop_front();
      total++;
      if (spi_tx_dat !== exp_b) begin
        $display("FAIL desel_b%0d got=%h want=%h", i, spi_tx_dat, exp_b); bad++;
      end
    end
    tx_pulse();  // now in the fetch cycle of byte 3
    ssel = 1'b1;
    #1;
    total++;
    if (fifo_rd !== 1'b0) begin
      $display("FAIL desel_nopop fifo_rd=%b want=0", fifo_rd); bad++;
    end
    settle(1);
    total++;
    if (busy !== 1'b0) begin
      $display("FAIL desel_idle busy=%b want=0", busy); bad++;
    end
    settle(3);
    tx_pulse();
    settle(3);
    total++;
    if (pops - p0 !== 2) begin
      $display("FAIL desel_pops got=%0d want=2", pops - p0); bad++;
    end
    total++;
    if (spi_tx_dat !== 8'h81) begin
      $display("FAIL desel_hold got=%h want=81", spi_tx_dat); bad++;
    end
    total++;
    if (regs_o !== regs_exp) begin
      $display("FAIL desel_regs got=%h want=%h", regs_o, regs_exp); bad++;
    end
    ssel = 1'b0;
    settle(2);
  endtask

  task automatic test_async_reset;
    exp_q.push_back(8'h82);
    rx_byte(8'h80);
    rx_byte(8'h04);
    settle(2);
    exp_b = exp_q.pop_front();
    total++;
    if (spi_tx_dat !== exp_b) begin
      $display("FAIL arst_b0 got=%h want=%h", spi_tx_dat, exp_b); bad++;
    end
    #3 rst = 1'b0;
    #1;
    total++;
    if ({spi_tx_dat, regs_o, fifo_rd, busy} !== 42'h0) begin
      $display("FAIL arst_outputs tx=%h regs=%h rd=%b busy=%b want all 0",
               spi_tx_dat, regs_o, fifo_rd, busy);
      bad++;
    end
    #2 rst = 1'b1;
    settle(2);
    exp_q.push_back(8'h1F);
    rx_byte(8'hC0);
    exp_b = exp_q.pop_front();
    total++;
    if (spi_tx_dat !== exp_b) begin
      $display("FAIL arst_stat got=%h want=%h", spi_tx_dat, exp_b); bad++;
    end
  endtask

  task automatic test_no_empty_pop;
    total++;
    if (bad_pops !== 0) begin
      $display("FAIL empty_pop count=%0d want=0", bad_pops); bad++;
    end
  endtask

  initial begin
    test_reset();
    test_wr_rd();
    test_bad_addr();
    test_burst3();
    test_underrun();
    test_len0();
    test_stat_sat();
    test_deselect();
    test_async_reset();
    test_no_empty_pop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
